// File: rtl/bram_reader_if.sv
// Memory read port and output stream bundle for bram_reader.
// Ports: raddr/rdata form the memory read port; m_data/m_valid/m_ready form the stream.
// master = the reader (drives raddr and the stream); slave = memory plus downstream sink.
interface bram_reader_if #(
   parameter int ADDR_ = 8,
   parameter int DATA_ = 8
);
   logic [ADDR_-1:0] raddr;
   logic [DATA_-1:0] rdata;
   logic [DATA_-1:0] m_data;
   logic             m_valid;
   logic             m_ready;

   modport master (
      output raddr,
      input  rdata,
      output m_data,
      output m_valid,
      input  m_ready
   );

   modport slave (
      input  raddr,
      output rdata,
      input  m_data,
      input  m_valid,
      output m_ready
   );
endinterface

// File: rtl/bram_reader.sv
// Purpose: burst reader; streams len words from a fixed-latency memory starting at base.
// Latency: first m_valid LAT_+1 cycles after the first raddr issue, then 1 word/cycle.
// Backpressure: m_ready low holds m_data; issue stops once LAT_+2 words are outstanding.
// Ports: clk, aclr_n (async active-low); start/base/len begin a burst, abort cancels it;
//        busy/done/err report status; bus (bram_reader_if.master) carries raddr/rdata and
//        the m_data/m_valid/m_ready stream.
// Option: define BRAM_READER_WRAP_EN to let bursts wrap past the top of the address space;
//         otherwise such a start is rejected with an err pulse.
module bram_reader #(
   parameter int ADDR_ = 8,
   parameter int DATA_ = 8,
   parameter int LAT_  = 2
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             start,
   input  logic [ADDR_-1:0] base,
   input  logic [ADDR_:0]   len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   bram_reader_if.master    bus
);
   localparam int DEPTH = LAT_ + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  CRED     = CW'(DEPTH);
   localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
   localparam logic [ADDR_:0] REM_ONE  = {{ADDR_{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [ADDR_-1:0] addr_q, addr_d;     // next address to issue
   logic [ADDR_-1:0] raddr_q, raddr_d;
   logic [ADDR_:0]   rem_q, rem_d;       // reads still to issue
   logic [CW-1:0]    outst_q, outst_d;   // issued but not yet transferred downstream
   logic [CW-1:0]    cnt_q, cnt_d;       // words held in the FIFO
   logic             iss_q, iss_d;       // raddr carries a fresh address this cycle
   logic [LAT_-1:0]  vld_q, vld_d;       // tracks each issued address until its rdata arrives
   logic [DATA_-1:0] fifo_q [DEPTH];
   logic [DATA_-1:0] fifo_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic             issue, pop, push, range_bad;

`ifdef BRAM_READER_WRAP_EN
   assign range_bad = 1'b0;
`else
   localparam logic [ADDR_+1:0] SPAN = {2'b01, {ADDR_{1'b0}}};
   assign range_bad = ({2'b00, base} + {1'b0, len}) > SPAN;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      raddr_d = raddr_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      pop  = (cnt_q != '0) && bus.m_ready;
      push = vld_q[LAT_-1];
      // A pop this cycle frees a credit, so a full pipe still sustains one word per cycle.
      issue = (state_q == RUN) && (rem_q != '0) && ((outst_q < CRED) || pop);

      iss_d    = issue;
      vld_d    = '0;
      vld_d[0] = iss_q;
      for (int i = 1; i < LAT_; i++) vld_d[i] = vld_q[i-1];

      fifo_d = fifo_q;
      if (push) fifo_d[wr_q] = bus.rdata;
      wr_d = push ? ((wr_q == LAST_PTR) ? '0 : wr_q + 1'b1) : wr_q;
      rd_d = pop  ? ((rd_q == LAST_PTR) ? '0 : rd_q + 1'b1) : rd_q;

      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;

      outst_d = outst_q;
      if (issue && !pop)      outst_d = outst_q + 1'b1;
      else if (!issue && pop) outst_d = outst_q - 1'b1;

      if (issue) begin
         raddr_d = addr_q;
         addr_d  = addr_q + 1'b1;
         rem_d   = rem_q - 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else if (range_bad) begin
                  err_d = 1'b1;
               end else begin
                  addr_d  = base;
                  rem_d   = len;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issue && (rem_q == REM_ONE)) state_d = DRAIN;
         end
         DRAIN: begin
            // Everything issued has now been handed downstream.
            if (outst_d == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over any transfer, issue or completion in the same cycle.
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         raddr_d = raddr_q;
         addr_d  = addr_q;
         rem_d   = '0;
         iss_d   = 1'b0;
         vld_d   = '0;
         cnt_d   = '0;
         outst_d = '0;
         wr_d    = '0;
         rd_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         raddr_q <= '0;
         rem_q   <= '0;
         outst_q <= '0;
         cnt_q   <= '0;
         iss_q   <= 1'b0;
         vld_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         raddr_q <= raddr_d;
         rem_q   <= rem_d;
         outst_q <= outst_d;
         cnt_q   <= cnt_d;
         iss_q   <= iss_d;
         vld_q   <= vld_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         fifo_q  <= fifo_d;
      end
   end

   assign bus.raddr   = raddr_q;
   assign bus.m_valid = (cnt_q != '0);
   assign bus.m_data  = fifo_q[rd_q];
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
endmodule

// File: tb/tb_bram_reader.sv
// Self-checking bench for bram_reader: memory model with mem[i]=i and a LAT-stage read pipe,
// a table of bursts run through a loop, and hand-written abort and reset sequences.
// Expected stream words are queued at start and compared as each transfer happens.
module tb_bram_reader;
   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int NV  = 8;

   logic          clk    = 1'b0;
   logic          aclr_n = 1'b1;
   logic          start  = 1'b0;
   logic          abort  = 1'b0;
   logic [AW-1:0] base   = '0;
   logic [AW:0]   len    = '0;
   logic          busy, done, err;

   bram_reader_if #(.ADDR_(AW), .DATA_(DW)) bus ();

   bram_reader #(.ADDR_(AW), .DATA_(DW), .LAT_(LAT)) dut (
      .clk   (clk),
      .aclr_n(aclr_n),
      .start (start),
      .base  (base),
      .len   (len),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem     [256];
   logic [DW-1:0] rd_pipe [LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem[bus.raddr];
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.rdata = rd_pipe[LAT-1];

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      int            stall;
      bit            rnd;
      bit            exp_err;
      bit            exp_done;
      int            exp_words;
      bit            chk_tim;
      bit            chk_stall;
   } vec_t;

   vec_t          tv [NV];
   logic [DW-1:0] sb_q [$];
   int n_pass = 0, n_tot = 0;
   int cyc = 0;
   int first_iss, first_vld, first_x, last_x, nx, ndone, nerr, done_cyc, n_iss;
   logic [AW-1:0] prev_raddr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                    name, act, act, exp, exp, cyc);
   endtask

   task automatic clr();
      first_iss = -1; first_vld = -1; first_x = -1; last_x = -1;
      nx = 0; ndone = 0; nerr = 0; done_cyc = -1; n_iss = 0;
   endtask

   task automatic push_exp(input logic [AW-1:0] b, input int n);
      logic [AW-1:0] a;
      for (int k = 0; k < n; k++) begin
         a = b + AW'(k);
         sb_q.push_back(mem[a]);
      end
   endtask

   // Called at a negedge with inputs settled; they hold through the coming posedge.
   task automatic step();
      logic          xfer, hold;
      logic [DW-1:0] xdat;
      xfer = bus.m_valid && bus.m_ready && !abort && aclr_n;
      hold = bus.m_valid && !bus.m_ready && !abort && aclr_n;
      xdat = bus.m_data;
      @(posedge clk);
      @(negedge clk);
      if (xfer) begin
         chk("word expected", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) chk("word data", xdat, sb_q.pop_front());
         if (nx == 0) first_x = cyc;
         last_x = cyc;
         nx++;
      end
      cyc++;
      if (hold && aclr_n) begin
         chk("hold valid", bus.m_valid, 1);
         chk("hold data", bus.m_data, xdat);
      end
      if (bus.raddr !== prev_raddr) begin
         if (n_iss == 0) first_iss = cyc;
         n_iss++;
         prev_raddr = bus.raddr;
      end
      if (bus.m_valid && first_vld < 0) first_vld = cyc;
      if (done) begin ndone++; done_cyc = cyc; end
      if (err) nerr++;
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (ndone != 0) break;
         step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = DW'(i);
      bus.m_ready = 1'b0;

      tv[0] = '{8'h10, 9'd4,  0,  1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0};
      tv[1] = '{8'h00, 9'd16, 10, 1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b1};
`ifdef BRAM_READER_WRAP_EN
      tv[2] = '{8'hFE, 9'd4,  0,  1'b0, 1'b0, 1'b1, 4,  1'b0, 1'b0};
`else
      tv[2] = '{8'hFE, 9'd4,  0,  1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b0};
`endif
      tv[3] = '{8'h33, 9'd0,  0,  1'b0, 1'b0, 1'b1, 0,  1'b0, 1'b0};
      tv[4] = '{8'hFC, 9'd4,  3,  1'b0, 1'b0, 1'b1, 4,  1'b0, 1'b0};
      tv[5] = '{8'h80, 9'd20, 0,  1'b1, 1'b0, 1'b1, 20, 1'b0, 1'b0};
      tv[6] = '{8'h20, 9'd1,  0,  1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b0};
`ifdef BRAM_READER_WRAP_EN
      tv[7] = '{8'hFF, 9'd2,  0,  1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0};
`else
      tv[7] = '{8'hFF, 9'd2,  0,  1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b0};
`endif

      // Reset state
      #1 aclr_n = 1'b0;
      #1;
      chk("reset raddr", bus.raddr, 0);
      chk("reset m_valid", bus.m_valid, 0);
      chk("reset m_data", bus.m_data, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      repeat (2) @(negedge clk);
      aclr_n = 1'b1;
      prev_raddr = bus.raddr;

      // Table-driven bursts
      for (int v = 0; v < NV; v++) begin
         clr();
         base  = tv[v].base;
         len   = tv[v].len;
         start = 1'b1;
         bus.m_ready = (tv[v].stall == 0);
         push_exp(tv[v].base, tv[v].exp_words);
         step();
         start = 1'b0;
         chk("busy after start", busy, 32'(tv[v].exp_words != 0));
         chk("err next cycle", err, 32'(tv[v].exp_err));
         chk("len0 done next cycle", done, 32'(tv[v].len == 0));
         for (int i = 0; i < 300; i++) begin
            if (ndone != 0 || nerr != 0) break;
            if (tv[v].chk_stall && i == tv[v].stall) begin
               chk("stall raddr stops", bus.raddr, 32'(tv[v].base + AW'(LAT + 1)));
               chk("stall issue count", n_iss, LAT + 2);
            end
            if (tv[v].rnd) bus.m_ready = 1'($urandom_range(0, 1));
            else           bus.m_ready = (i >= tv[v].stall);
            step();
         end
         bus.m_ready = 1'b1;
         repeat (3) step();
         chk("done pulses", ndone, 32'(tv[v].exp_done));
         chk("err pulses", nerr, 32'(tv[v].exp_err));
         chk("word count", nx, tv[v].exp_words);
         chk("scoreboard empty", sb_q.size(), 0);
         chk("busy at end", busy, 0);
         if (tv[v].exp_words == 0) begin
            chk("no reads issued", n_iss, 0);
            chk("m_valid never", first_vld, -1);
         end
         if (tv[v].chk_tim) begin
            chk("first valid latency", first_vld - first_iss, LAT + 1);
            chk("back-to-back words", last_x - first_x, tv[v].exp_words - 1);
            chk("done after last", done_cyc - last_x, 1);
         end
         sb_q.delete();
      end

      // Abort after the third transfer, with m_ready still high
      clr();
      base = 8'h50; len = 9'd8; start = 1'b1; bus.m_ready = 1'b1;
      push_exp(8'h50, 8);
      step();
      start = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (nx >= 3) break;
         step();
      end
      chk("abort pre count", nx, 3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort drops valid", bus.m_valid, 0);
      chk("abort clears busy", busy, 0);
      sb_q.delete();
      repeat (6) step();
      chk("abort no done", ndone, 0);
      chk("abort no more words", nx, 3);
      chk("abort valid stays low", bus.m_valid, 0);
      clr();
      base = 8'h40; len = 9'd1; start = 1'b1;
      push_exp(8'h40, 1);
      step();
      start = 1'b0;
      run_until_done(40);
      chk("post-abort done", ndone, 1);
      chk("post-abort words", nx, 1);
      chk("post-abort sb empty", sb_q.size(), 0);

      // One-cycle reset in the middle of a burst
      clr();
      base = 8'h60; len = 9'd8; start = 1'b1; bus.m_ready = 1'b1;
      push_exp(8'h60, 8);
      step();
      start = 1'b0;
      repeat (5) step();
      aclr_n = 1'b0;
      #1;
      chk("mid reset raddr", bus.raddr, 0);
      chk("mid reset m_valid", bus.m_valid, 0);
      chk("mid reset m_data", bus.m_data, 0);
      chk("mid reset busy", busy, 0);
      chk("mid reset done", done, 0);
      chk("mid reset err", err, 0);
      @(negedge clk);
      step();
      chk("reset no done", ndone, 0);
      aclr_n = 1'b1;
      sb_q.delete();
      clr();
      prev_raddr = bus.raddr;
      base = 8'h70; len = 9'd3; start = 1'b1;
      push_exp(8'h70, 3);
      step();
      start = 1'b0;
      chk("start after reset busy", busy, 1);
      run_until_done(40);
      chk("post-reset done", ndone, 1);
      chk("post-reset words", nx, 3);
      chk("post-reset sb empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
